// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory bus bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_DEPTH = 14,
    parameter int DATA_WIDTH = 32
);
    // Requester side: index 0 = core LSU, index 1 = DMA/debug
    logic [1:0]                 REQ;
    logic [1:0]                 REQ_WE;
    logic [1:0][31:0]           REQ_ADDR;
    logic [1:0][DATA_WIDTH-1:0] REQ_WDATA;
    logic [1:0][1:0]            REQ_BSEL;
    logic [1:0]                 REQ_SIGN;
    logic [1:0]                 REQ_READY;
    logic [1:0]                 RSP_VALID;
    logic [DATA_WIDTH-1:0]      RSP_RDATA;
    logic                       RSP_ERR;

    // Memory side
    logic                       MEM_RDEN;
    logic                       MEM_WEN;
    logic [ADDR_DEPTH-1:0]      MEM_ADDR;
    logic [1:0]                 MEM_BSEL;
    logic                       MEM_SIGN;
    logic [DATA_WIDTH-1:0]      MEM_WDATA;
    logic [DATA_WIDTH-1:0]      MEM_RDATA;

    // Arbiter view: serves the requesters, drives the memory
    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BSEL, REQ_SIGN, MEM_RDATA,
        output REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        output MEM_RDEN, MEM_WEN, MEM_ADDR, MEM_BSEL, MEM_SIGN, MEM_WDATA
    );

    // Environment view: requesters plus the memory model
    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_WDATA, REQ_BSEL, REQ_SIGN, MEM_RDATA,
        input  REQ_READY, RSP_VALID, RSP_RDATA, RSP_ERR,
        input  MEM_RDEN, MEM_WEN, MEM_ADDR, MEM_BSEL, MEM_SIGN, MEM_WDATA
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, one transaction in flight (DMEM_ARB_RR_EN selects round-robin)
module dmem_arbiter #(
    parameter int ADDR_DEPTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic           CLK,
    input  logic           RST,
    dmem_arbiter_if.slave  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]            state;

    logic                  gnt;
    logic                  accept;
    logic [31:0]           sel_addr;
    logic [1:0]            sel_bsel;
    logic                  sel_err;

    logic                  cmd_owner;
    logic                  cmd_we;
    logic [ADDR_DEPTH-1:0] cmd_waddr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [1:0]            cmd_bsel;
    logic                  cmd_sign;
    logic                  cmd_err;

    logic                  in_issue;
    logic                  in_resp;

`ifdef DMEM_ARB_RR_EN
    logic                  last_gnt;

    // Round-robin: on a tie the port not granted last wins
    always_comb begin
        gnt = bus.REQ[1];
        if (bus.REQ == 2'b11) begin
            gnt = ~last_gnt;
        end
    end

    // Pointer follows every grant; reset value 1 lets port 0 win the first tie
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_gnt <= 1'b1;
        end else if (accept) begin
            last_gnt <= gnt;
        end
    end
`else
    // Fixed priority: port 0 wins whenever it requests
    always_comb begin
        gnt = ~bus.REQ[0];
    end
`endif

    // Acceptance and alignment / range check of the winning request
    always_comb begin
        accept   = (state == S_IDLE) && (bus.REQ != 2'b00) && !RST;
        sel_addr = bus.REQ_ADDR[gnt];
        sel_bsel = bus.REQ_BSEL[gnt];
        sel_err  = (sel_addr >> (ADDR_DEPTH + 2)) != 32'd0;
        if (sel_bsel[1]) begin
            sel_err = sel_err | (sel_addr[1:0] != 2'b00);
        end else if (sel_bsel[0]) begin
            sel_err = sel_err | sel_addr[0];
        end
    end

    // Transaction FSM: IDLE -> ISSUE -> RESP -> IDLE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state <= S_ISSUE;
                S_ISSUE: state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Command register captures the granted request at acceptance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cmd_owner <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_waddr <= '0;
            cmd_wdata <= '0;
            cmd_bsel  <= 2'b00;
            cmd_sign  <= 1'b0;
            cmd_err   <= 1'b0;
        end else if (accept) begin
            cmd_owner <= gnt;
            cmd_we    <= bus.REQ_WE[gnt];
            cmd_waddr <= sel_addr[ADDR_DEPTH+1:2];
            cmd_wdata <= bus.REQ_WDATA[gnt];
            cmd_bsel  <= sel_bsel;
            cmd_sign  <= bus.REQ_SIGN[gnt];
            cmd_err   <= sel_err;
        end
    end

    // Outputs decode from state so reset clears them without waiting for a clock
    always_comb begin
        in_issue      = (state == S_ISSUE);
        in_resp       = (state == S_RESP);

        bus.REQ_READY = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;

        bus.MEM_RDEN  = in_issue && !cmd_we && !cmd_err;
        bus.MEM_WEN   = in_issue && cmd_we && !cmd_err;
        bus.MEM_ADDR  = in_issue ? cmd_waddr : '0;
        bus.MEM_WDATA = in_issue ? cmd_wdata : '0;
        bus.MEM_BSEL  = in_issue ? cmd_bsel : 2'b00;
        bus.MEM_SIGN  = in_issue && cmd_sign;

        bus.RSP_VALID = in_resp ? (cmd_owner ? 2'b10 : 2'b01) : 2'b00;
        bus.RSP_ERR   = in_resp && cmd_err;
        bus.RSP_RDATA = (in_resp && !cmd_we && !cmd_err) ? bus.MEM_RDATA : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a word-array reference model
module tb_dmem_arbiter;
    localparam int AD    = 14;
    localparam int DW    = 32;
    localparam int WORDS = 1 << AD;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    dmem_arbiter_if #(.ADDR_DEPTH(AD), .DATA_WIDTH(DW)) bus ();

    dmem_arbiter #(.ADDR_DEPTH(AD), .DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Environment memory: registered read one cycle after MEM_RDEN
    logic [DW-1:0] env_mem [0:WORDS-1];
    logic [DW-1:0] mem_rdata = '0;
    assign bus.MEM_RDATA = mem_rdata;
    always @(posedge CLK) begin
        if (bus.MEM_WEN) env_mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
        if (bus.MEM_RDEN) mem_rdata <= env_mem[bus.MEM_ADDR];
    end

    // Reference: what every memory word should hold
    logic [DW-1:0] ref_mem [0:WORDS-1];

    function automatic logic [DW-1:0] seed_word(input int i);
        return (i * 32'h9E37_79B9) ^ 32'h5A5A_0000;
    endfunction

    function automatic bit addr_bad(input logic [31:0] a, input logic [1:0] bs);
        if (a[31:AD+2] != 0) return 1'b1;
        if (bs == 2'b01) return a[0];
        if (bs[1]) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        bus.REQ = 2'b00;
        bus.REQ_WE = 2'b00;
        bus.REQ_ADDR = '0;
        bus.REQ_WDATA = '0;
        bus.REQ_BSEL = '0;
        bus.REQ_SIGN = 2'b00;
    endtask

    // One single-port transaction from IDLE, checked cycle by cycle
    task automatic do_txn(input int p, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] bs, input bit sg);
        bit            err;
        int            w;
        logic [1:0]    oh;
        logic [DW-1:0] exp_rd;
        err = addr_bad(addr, bs);
        w = int'(addr[AD+1:2]);
        oh = (p == 1) ? 2'b10 : 2'b01;
        exp_rd = (we || err) ? '0 : ref_mem[w];

        @(posedge CLK); #1;
        bus.REQ[p] = 1'b1;
        bus.REQ_WE[p] = we;
        bus.REQ_ADDR[p] = addr;
        bus.REQ_WDATA[p] = wd;
        bus.REQ_BSEL[p] = bs;
        bus.REQ_SIGN[p] = sg;
        @(negedge CLK);
        chk("ready", {62'd0, bus.REQ_READY}, {62'd0, oh});
        chk("idle_mem_en", {62'd0, bus.MEM_RDEN, bus.MEM_WEN}, 64'd0);

        @(posedge CLK); #1;
        clear_req();
        @(negedge CLK);
        chk("issue_rden", {63'd0, bus.MEM_RDEN}, {63'd0, !we && !err});
        chk("issue_wen", {63'd0, bus.MEM_WEN}, {63'd0, we && !err});
        chk("issue_ready", {62'd0, bus.REQ_READY}, 64'd0);
        if (!err) begin
            chk("issue_addr", {50'd0, bus.MEM_ADDR}, {50'd0, addr[AD+1:2]});
            chk("issue_bsel", {62'd0, bus.MEM_BSEL}, {62'd0, bs});
            chk("issue_sign", {63'd0, bus.MEM_SIGN}, {63'd0, sg});
            if (we) chk("issue_wdata", {32'd0, bus.MEM_WDATA}, {32'd0, wd});
        end

        @(posedge CLK);
        @(negedge CLK);
        chk("rsp_valid", {62'd0, bus.RSP_VALID}, {62'd0, oh});
        chk("rsp_err", {63'd0, bus.RSP_ERR}, {63'd0, err});
        chk("rsp_rdata", {32'd0, bus.RSP_RDATA}, {32'd0, exp_rd});
        chk("rsp_mem_en", {62'd0, bus.MEM_RDEN, bus.MEM_WEN}, 64'd0);
        if (we && !err) ref_mem[w] = wd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int last_cyc;
        int winner;
        int exp_winner;
        logic [31:0] a;

        for (int i = 0; i < WORDS; i++) begin
            env_mem[i] = seed_word(i);
            ref_mem[i] = seed_word(i);
        end
        clear_req();

        // Reset state
        @(negedge CLK);
        chk("rst_ready", {62'd0, bus.REQ_READY}, 64'd0);
        chk("rst_rsp", {29'd0, bus.RSP_VALID, bus.RSP_ERR, 32'd0} | {32'd0, bus.RSP_RDATA}, 64'd0);
        chk("rst_mem", {45'd0, bus.MEM_RDEN, bus.MEM_WEN, bus.MEM_ADDR, bus.MEM_BSEL, bus.MEM_SIGN}, 64'd0);
        chk("rst_wdata", {32'd0, bus.MEM_WDATA}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Both ports request continuously: count six grants and their spacing
        bus.REQ = 2'b11;
        bus.REQ_ADDR[0] = 32'h10;
        bus.REQ_ADDR[1] = 32'h14;
        bus.REQ_BSEL[0] = 2'b10;
        bus.REQ_BSEL[1] = 2'b10;
        grants = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && grants < 6; cyc++) begin
            @(negedge CLK);
            if (bus.REQ_READY != 2'b00) begin
`ifdef DMEM_ARB_RR_EN
                exp_winner = grants % 2;
`else
                exp_winner = 0;
`endif
                winner = bus.REQ_READY[1] ? 1 : 0;
                chk("tie_grant", 64'(winner), 64'(exp_winner));
                chk("tie_onehot", {62'd0, bus.REQ_READY}, (exp_winner == 1) ? 64'd2 : 64'd1);
                if (grants > 0) chk("tie_spacing", 64'(cyc - last_cyc), 64'd3);
                last_cyc = cyc;
                grants++;
            end
        end
        chk("tie_count", 64'(grants), 64'd6);
        @(posedge CLK); #1;
        clear_req();
        repeat (3) @(posedge CLK);

        // Port 0 word write then read of 0x10
        do_txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0);
        do_txn(0, 1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0);
        // Port 1 misaligned word read
        do_txn(1, 1'b0, 32'h0000_0006, 32'h0, 2'b10, 1'b0);
        // Port 0 out-of-range byte read
        do_txn(0, 1'b0, 32'h0001_0000, 32'h0, 2'b00, 1'b1);
        // Port 1 misaligned half write must leave memory untouched
        do_txn(1, 1'b1, 32'h0000_0011, 32'h1234_5678, 2'b01, 1'b0);
        do_txn(1, 1'b0, 32'h0000_0010, 32'h0, 2'b10, 1'b0);
        // Highest in-range word
        do_txn(1, 1'b1, 32'h0000_FFFC, 32'hCAFE_F00D, 2'b10, 1'b0);
        do_txn(0, 1'b0, 32'h0000_FFFC, 32'h0, 2'b10, 1'b1);

        // Randomized single-port traffic
        for (int k = 0; k < 30; k++) begin
            int kind;
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                a = {16'($urandom_range(1, 65535)), 16'($urandom)};
            end else begin
                a = 32'($urandom_range(0, 63)) << 2;
                if (kind == 1) a[1:0] = 2'($urandom_range(0, 3));
            end
            do_txn($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom,
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        // Reset during the ISSUE cycle of a port 0 write to 0x20
        @(posedge CLK); #1;
        bus.REQ[0] = 1'b1;
        bus.REQ_WE[0] = 1'b1;
        bus.REQ_ADDR[0] = 32'h20;
        bus.REQ_WDATA[0] = 32'h0BAD_0BAD;
        bus.REQ_BSEL[0] = 2'b10;
        @(negedge CLK);
        chk("rst_txn_ready", {62'd0, bus.REQ_READY}, 64'd1);
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("rst_mid_ready", {62'd0, bus.REQ_READY}, 64'd0);
        chk("rst_mid_mem", {45'd0, bus.MEM_RDEN, bus.MEM_WEN, bus.MEM_ADDR, bus.MEM_BSEL, bus.MEM_SIGN}, 64'd0);
        chk("rst_mid_wdata", {32'd0, bus.MEM_WDATA}, 64'd0);
        chk("rst_mid_rsp", {29'd0, bus.RSP_VALID, bus.RSP_ERR, 32'd0} | {32'd0, bus.RSP_RDATA}, 64'd0);
        clear_req();
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            chk("rst_no_rsp", {62'd0, bus.RSP_VALID}, 64'd0);
        end
        do_txn(0, 1'b0, 32'h0000_0020, 32'h0, 2'b10, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_DEPTH, default 14: data-memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: data width.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ  input  [1:0]  request valid per requester; index 0 = core LSU, index 1 = DMA/debug.
REQ-006 REQ_WE  input  [1:0]  1 = write, 0 = read, per requester.
REQ-007 REQ_ADDR  input  [1:0][31:0]  byte address per requester.
REQ-008 REQ_WDATA  input  [1:0][DATA_WIDTH-1:0]  write data per requester.
REQ-009 REQ_BSEL  input  [1:0][1:0]  access size per requester: 00 byte, 01 half, 10/11 word.
REQ-010 REQ_SIGN  input  [1:0]  sign flag per requester, forwarded unchanged.
REQ-011 REQ_READY  output  [1:0]  request accepted this cycle (one-hot or zero).
REQ-012 RSP_VALID  output  [1:0]  one-cycle response strobe to the owning requester; no back-pressure.
REQ-013 RSP_RDATA  output  DATA_WIDTH  read data, shared; valid only with RSP_VALID.
REQ-014 RSP_ERR  output  1  error flag, shared; valid only with RSP_VALID.
REQ-015 MEM_RDEN, MEM_WEN  output  1 each  memory read / write enable.
REQ-016 MEM_ADDR  output  ADDR_DEPTH  memory word address.
REQ-017 MEM_BSEL  output  2; MEM_SIGN  output  1; MEM_WDATA  output  DATA_WIDTH  memory command fields.
REQ-018 MEM_RDATA  input  DATA_WIDTH  memory read data, registered one cycle after MEM_RDEN.

Function
REQ-019 FSM states IDLE, ISSUE, RESP; one transaction outstanding at a time.
REQ-020 IDLE: if any REQ bit set, grant one requester, assert its REQ_READY combinationally, latch its fields into the command register, go to ISSUE; else stay IDLE.
REQ-021 REQ_READY is 0 in ISSUE and RESP; requesters hold REQ and fields stable until REQ_READY.
REQ-022 ISSUE: drive MEM_* from the command register for exactly one cycle; MEM_ADDR = addr[ADDR_DEPTH+1:2]; go to RESP.
REQ-023 RESP: assert RSP_VALID[owner] for one cycle; RSP_RDATA = MEM_RDATA for reads, 0 for writes; go to IDLE.
REQ-024 Latency: acceptance in cycle N -> memory access in N+1 -> RSP_VALID in N+2; one transaction per 3 cycles maximum.
REQ-025 Error check at acceptance: word access with addr[1:0] != 0, half access with addr[0] != 0, or addr[31:ADDR_DEPTH+2] != 0 sets the latched error bit.
REQ-026 Errored transaction: MEM_RDEN = MEM_WEN = 0 in ISSUE (memory untouched); RESP gives RSP_ERR = 1, RSP_RDATA = 0; timing unchanged.
REQ-027 Outside ISSUE, MEM_RDEN = MEM_WEN = 0 and MEM_ADDR/MEM_WDATA/MEM_BSEL/MEM_SIGN = 0.
REQ-028 Both REQ bits set in IDLE: winner chosen per REQ-033; loser waits with REQ held, no response.
REQ-029 REQ deasserted in ISSUE/RESP has no effect; the latched transaction completes.

Reset
REQ-030 RST asserted: FSM to IDLE immediately; REQ_READY, RSP_VALID, RSP_ERR, RSP_RDATA, all MEM_* outputs 0; last-grant pointer to 1 (port 0 wins first tie).
REQ-031 RST during ISSUE or RESP aborts the transaction; no RSP_VALID is produced for it after reset release.

Configuration
REQ-032 Macro DMEM_ARB_RR_EN selects the arbitration policy.
REQ-033 Defined: round-robin, tie goes to the port not granted last, pointer updated on every grant; undefined: fixed priority, port 0 always wins ties, pointer logic absent.

Verification
REQ-034 Port 0 word write addr 0x0000_0010 data 0xDEAD_BEEF, then word read 0x10 -> MEM_ADDR = 0x004 in both ISSUE cycles; read RSP_RDATA = 0xDEAD_BEEF, RSP_ERR = 0, RSP_VALID[0] at acceptance+2.
REQ-035 Port 1 word read addr 0x0000_0006 -> no MEM_RDEN/MEM_WEN pulse; RSP_VALID[1] at acceptance+2 with RSP_ERR = 1, RSP_RDATA = 0.
REQ-036 Port 0 byte read addr 0x0001_0000 (ADDR_DEPTH = 14) -> out of range, RSP_ERR = 1, memory untouched.
REQ-037 Both ports request continuously for 6 transactions -> with DMEM_ARB_RR_EN grants 0,1,0,1,0,1; without it grants 0,0,0,0,0,0 and port 1 is never ready.
REQ-038 Assert RST in ISSUE of a port 0 write to 0x20 -> outputs 0 immediately, no RSP_VALID after release, subsequent read of 0x20 returns its pre-write value.
